pattern_detector_prog: RTL and testbench

Runtime-programmable serial pattern detector; the parametrised successor to the team's fixed 5-symbol Bike/Car detector. It accepts a 1-bit symbol stream qualified by `valid_in` and matches it against a software-loaded pattern of 1..MAX_LEN symbols. The match mode is selectable between overlapping and non-overlapping. It counts matches in a saturating counter. It sits between the sensor symbol front-end and the event/statistics logic.

---
 rtl/pattern_det_pkg.sv | 17 +
 rtl/sat_counter.sv | 27 ++
 rtl/pattern_detector_prog.sv | 106 ++++++++++
 tb/tb_pattern_detector_prog.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package pattern_det_pkg;

   typedef enum logic [1:0] {
      ST_UNCFG = 2'd0,
      ST_FILL  = 2'd1,
      ST_ARMED = 2'd2
   } state_e;

   localparam logic SYM_C = 1'b0;
   localparam logic SYM_B = 1'b1;

   // Legacy fixed detector pattern B,C,C,B,C (first symbol in the MSB)
   localparam logic [4:0]  BCCBC     = 5'b10010;
   localparam int unsigned BCCBC_LEN = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear and an increment in the same cycle yield 1.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d, base_c;

   always_comb begin
      base_c  = clr ? '0 : count_q;
      count_d = base_c;
      if (inc && (base_c != '1)) count_d = base_c + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pattern_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap/non-overlap modes
// and a saturating match counter.
module pattern_detector_prog
   import pattern_det_pkg::*;
#(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               cfg_err,
   input  logic               d_in,
   input  logic               valid_in,
   output logic               match,
   input  logic               count_clr,
   output logic [CNT_W-1:0]   match_count,
   output logic               configured
);

   state_e             state_q;
   // Only the previous MAX_LEN-1 symbols are kept; the current beat completes the window
   logic [MAX_LEN-2:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic               match_q, cfg_err_q, configured_q;

   logic [MAX_LEN-1:0] win_c, mask_c;
   logic [MAX_LEN:0]   one_hot_c;
   logic [LEN_W:0]     fill_inc_c;
   logic               window_full_c, beat_c, hit_c, cfg_legal_c;

   // Window compare against the latched pattern, masked to the active length
   always_comb begin
      win_c         = {hist_q, d_in};
      one_hot_c     = (MAX_LEN+1)'(1) << len_q;
      mask_c        = MAX_LEN'(one_hot_c - (MAX_LEN+1)'(1));
      fill_inc_c    = {1'b0, fill_q} + (LEN_W+1)'(1);
      window_full_c = (fill_inc_c >= {1'b0, len_q});
      beat_c        = valid_in && !cfg_we && (state_q != ST_UNCFG);
      hit_c         = beat_c && window_full_c && (((win_c ^ pat_q) & mask_c) == '0);
      cfg_legal_c   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   end

   // FSM and datapath; a configuration write takes priority over a data beat
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_UNCFG;
         hist_q       <= '0;
         fill_q       <= '0;
         pat_q        <= '0;
         len_q        <= '0;
         ovl_q        <= 1'b0;
         match_q      <= 1'b0;
         cfg_err_q    <= 1'b0;
         configured_q <= 1'b0;
      end else begin
         match_q   <= hit_c;
         cfg_err_q <= 1'b0;
         if (cfg_we) begin
            if (cfg_legal_c) begin
               pat_q        <= cfg_pattern;
               len_q        <= cfg_len;
               ovl_q        <= cfg_overlap;
               hist_q       <= '0;
               fill_q       <= '0;
               state_q      <= ST_FILL;
               configured_q <= 1'b1;
            end else begin
               cfg_err_q <= 1'b1;
            end
         end else if (beat_c) begin
            hist_q <= win_c[MAX_LEN-2:0];
            if (hit_c && !ovl_q) begin
               fill_q  <= '0;
               state_q <= ST_FILL;
            end else if (window_full_c) begin
               fill_q  <= len_q;
               state_q <= ST_ARMED;
            end else begin
               fill_q  <= fill_inc_c[LEN_W-1:0];
               state_q <= ST_FILL;
            end
         end
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (count_clr),
      .inc   (hit_c),
      .count (match_count)
   );

   assign match      = match_q;
   assign cfg_err    = cfg_err_q;
   assign configured = configured_q;

endmodule

// File: tb/tb_pattern_detector_prog.sv
// Scoreboard bench: two detectors (16-bit and 2-bit counters) share stimulus and
// are checked every cycle against a symbol-queue reference model.
module tb_pattern_detector_prog;
   import pattern_det_pkg::*;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned LEN_W   = 4;

   logic               clk = 1'b0;
   logic               reset, cfg_we, cfg_overlap, d_in, valid_in, count_clr;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_err, match, configured;
   logic               cfg_err2, match2, configured2;
   logic [15:0]        match_count;
   logic [1:0]         match_count2;

   always #5 clk = ~clk;

   pattern_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
      .d_in(d_in), .valid_in(valid_in), .match(match), .count_clr(count_clr),
      .match_count(match_count), .configured(configured));

   pattern_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
      .d_in(d_in), .valid_in(valid_in), .match(match2), .count_clr(count_clr),
      .match_count(match_count2), .configured(configured2));

   typedef struct {
      bit m;
      bit err;
      bit conf;
      int c16;
      int c2;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: recent symbols since the last (re)start, oldest first
   bit       m_conf = 0;
   bit [7:0] m_pat  = '0;
   int       m_len  = 0;
   bit       m_ovl  = 0;
   bit       m_sym[$];
   int       m_c16  = 0;
   int       m_c2   = 0;

   function automatic void chk(string name, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, want);
      end
   endfunction

   task automatic step(input bit rst, input bit we, input bit [7:0] pat, input int len,
                       input bit ovl, input bit v, input bit d, input bit clr);
      exp_t e;
      bit   hit;
      @(negedge clk);
      reset = rst; cfg_we = we; cfg_pattern = pat; cfg_len = 4'(len);
      cfg_overlap = ovl; valid_in = v; d_in = d; count_clr = clr;
      hit   = 0;
      e.err = 0;
      if (rst) begin
         m_conf = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_sym.delete();
         m_c16 = 0; m_c2 = 0;
      end else begin
         if (we) begin
            if (len >= 1 && len <= MAX_LEN) begin
               m_conf = 1; m_pat = pat; m_len = len; m_ovl = ovl; m_sym.delete();
            end else begin
               e.err = 1;
            end
         end else if (v && m_conf) begin
            m_sym.push_back(d);
            if (m_sym.size() > m_len) void'(m_sym.pop_front());
            if (m_sym.size() == m_len) begin
               hit = 1;
               for (int i = 0; i < m_len; i++)
                  if (m_sym[i] != m_pat[m_len-1-i]) hit = 0;
            end
            if (hit && !m_ovl) m_sym.delete();
         end
         if (clr) begin m_c16 = 0; m_c2 = 0; end
         if (hit) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c2 < 3) m_c2++;
         end
      end
      e.m = hit; e.conf = m_conf; e.c16 = m_c16; e.c2 = m_c2;
      exp_q.push_back(e);
   endtask

   task automatic idle();                    step(0, 0, '0, 0, 0, 0, 0, 0); endtask
   task automatic beat(input bit d);         step(0, 0, '0, 0, 0, 1, d, 0); endtask
   task automatic clr_cnt();                 step(0, 0, '0, 0, 0, 0, 0, 1); endtask
   task automatic do_reset();                step(1, 0, '0, 0, 0, 0, 0, 0); endtask
   task automatic load(input bit [7:0] p, input int len, input bit ovl);
      step(0, 1, p, len, ovl, 0, 0, 0);
   endtask
   task automatic stream(input bit [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) beat(bits[i]);
   endtask

   // Monitor: compare every registered output one step after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("match",        int'(match),        int'(e.m));
            chk("cfg_err",      int'(cfg_err),      int'(e.err));
            chk("configured",   int'(configured),   int'(e.conf));
            chk("match_count",  int'(match_count),  e.c16);
            chk("match2",       int'(match2),       int'(e.m));
            chk("match_count2", int'(match_count2), e.c2);
         end
      end
   end

   initial begin
      bit [7:0] pat;
      int       r, len;
      reset = 1; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
      valid_in = 0; d_in = 0; count_clr = 0;
      do_reset(); do_reset(); idle();

      // Illegal load from reset: stays unconfigured, beats ignored
      load(8'h01, 0, 1);
      for (int i = 0; i < 4; i++) beat(SYM_B);

      // Non-overlap then overlap BCCBC on 1,0,0,1,0,0,1,0
      load({3'b0, BCCBC}, BCCBC_LEN, 0); stream(8'b1001_0010, 8); idle();
      clr_cnt();
      load({3'b0, BCCBC}, BCCBC_LEN, 1); stream(8'b1001_0010, 8); idle();

      // Gaps between every beat
      load({3'b0, BCCBC}, BCCBC_LEN, 0);
      for (int i = 4; i >= 0; i--) begin beat(BCCBC[i]); idle(); idle(); end

      // Config write coincident with a beat: beat dropped, fill restarts
      load(8'b101, 3, 1); beat(1); beat(0);
      step(0, 1, 8'b101, 3, 1, 1, 1, 0);
      beat(0); beat(1); beat(1); beat(0); beat(1);

      // Illegal loads while holding len 3
      load(8'b101, 3, 0); beat(1);
      load(8'hFF, 0, 0); load(8'hFF, MAX_LEN + 1, 1);
      beat(0); beat(1); idle();

      // Counter saturation at 2 bits, then clear coincident with a match
      clr_cnt(); load(8'h01, 1, 1);
      for (int i = 0; i < 5; i++) beat(SYM_B);
      step(0, 0, '0, 0, 0, 1, 1, 1); idle();

      // Reset mid-pattern, reload, final beat alone must not match
      load({3'b0, BCCBC}, BCCBC_LEN, 0); stream(8'b1001, 4);
      do_reset(); idle();
      load({3'b0, BCCBC}, BCCBC_LEN, 0); beat(SYM_C); idle();

      // Randomized traffic with sporadic reconfiguration, clears and resets
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 199);
         if (r < 6) begin
            len = (r < 1) ? $urandom_range(0, MAX_LEN + 1) : $urandom_range(1, 4);
            pat = 8'($urandom);
            load(pat, len, 1'($urandom));
         end else if (r < 9) begin
            step(0, 0, '0, 0, 0, 1'($urandom), 1'($urandom), 1);
         end else if (r == 199) begin
            do_reset();
         end else begin
            step(0, 0, '0, 0, 0, $urandom_range(0, 3) != 0, 1'($urandom), 0);
         end
      end
      idle();

      @(posedge clk);
      #2;
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
